// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, fixed-latency imem requests,
// epoch-tagged in-flight pipe and a small instruction queue toward decode.
module if_fetch_queue #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int unsigned       PC_STEP     = 4,
   parameter int unsigned       MEM_LAT     = 1,
   parameter int unsigned       QUEUE_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          pc_write,
   input  logic                          redirect_valid,
   input  logic [ADDR_W-1:0]             redirect_pc,
   output logic                          imem_req,
   output logic [ADDR_W-1:0]             imem_addr,
   input  logic [DATA_W-1:0]             imem_rdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_W-1:0]             out_instr,
   output logic [ADDR_W-1:0]             out_pc,
   output logic [ADDR_W-1:0]             out_pc_plus4,
   output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 3;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0] fetch_pc;
   logic              epoch;

   logic [MEM_LAT-1:0] pv;
   logic [MEM_LAT-1:0] pep;
   logic [ADDR_W-1:0]  ppc [MEM_LAT];

   logic [DATA_W-1:0] q_instr [QUEUE_DEPTH];
   logic [ADDR_W-1:0] q_pc    [QUEUE_DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;

   logic [SW-1:0] inflight;
   logic          land;
   logic          push;
   logic          pop;

   // Only current-epoch requests hold a credit; stale ones are dead.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++)
         inflight = inflight + SW'(pv[i] && (pep[i] == epoch));
   end

   assign land = pv[MEM_LAT-1] && (pep[MEM_LAT-1] == epoch);
   assign push = land && !redirect_valid;
   assign pop  = out_valid && out_ready && !redirect_valid;

   assign imem_req = !reset && pc_write && !redirect_valid &&
                     ((SW'(count) + inflight) < SW'(QUEUE_DEPTH));
   assign imem_addr = fetch_pc;

   assign out_valid    = (count != '0);
   assign out_instr    = out_valid ? q_instr[rd_ptr] : '0;
   assign out_pc       = out_valid ? q_pc[rd_ptr] : '0;
   assign out_pc_plus4 = out_valid ? q_pc[rd_ptr] + STEP : '0;
   assign queue_count  = count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         epoch    <= 1'b0;
         pv       <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         pv[0] <= imem_req;
         for (int i = 1; i < MEM_LAT; i++)
            pv[i] <= pv[i-1];
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            epoch    <= ~epoch;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (imem_req)
               fetch_pc <= fetch_pc + STEP;
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clock) begin
      ppc[0] <= fetch_pc;
      pep[0] <= epoch;
      for (int i = 1; i < MEM_LAT; i++) begin
         ppc[i] <= ppc[i-1];
         pep[i] <= pep[i-1];
      end
      if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]    <= ppc[MEM_LAT-1];
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench: MEM_LAT=1 instance for flow/stall/redirect,
// MEM_LAT=3 instance for wrap, mid-stream reset and stale-response drop.
module tb_if_fetch_queue;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic        rst_a, pw_a, rv_a, req_a, ov_a, ordy_a;
   logic [31:0] rpc_a, addr_a, rdata_a, instr_a, pc_a, p4_a;
   logic [2:0]  cnt_a;

   logic        rst_b, pw_b, rv_b, req_b, ov_b, ordy_b;
   logic [31:0] rpc_b, addr_b, rdata_b, instr_b, pc_b, p4_b;
   logic [2:0]  cnt_b;
   logic [31:0] b1, b2;

   if_fetch_queue #(.MEM_LAT(1)) dut_a (
      .clock(clk), .reset(rst_a), .pc_write(pw_a),
      .redirect_valid(rv_a), .redirect_pc(rpc_a),
      .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
      .out_valid(ov_a), .out_ready(ordy_a), .out_instr(instr_a),
      .out_pc(pc_a), .out_pc_plus4(p4_a), .queue_count(cnt_a)
   );

   if_fetch_queue #(.MEM_LAT(3), .RESET_PC(32'hFFFF_FFF8)) dut_b (
      .clock(clk), .reset(rst_b), .pc_write(pw_b),
      .redirect_valid(rv_b), .redirect_pc(rpc_b),
      .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
      .out_valid(ov_b), .out_ready(ordy_b), .out_instr(instr_b),
      .out_pc(pc_b), .out_pc_plus4(p4_b), .queue_count(cnt_b)
   );

   // Memory models: data = addr ^ K, returned after the fixed latency.
   always @(posedge clk) rdata_a <= addr_a ^ K;
   always @(posedge clk) begin
      b1      <= addr_b ^ K;
      b2      <= b1;
      rdata_b <= b2;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_a = 1; pw_a = 1; rv_a = 0; rpc_a = 0; ordy_a = 0;
      rst_b = 1; pw_b = 1; rv_b = 0; rpc_b = 0; ordy_b = 1;
      repeat (2) @(posedge clk);
      #2;
      check("rst_req",   32'(req_a), 0);
      check("rst_valid", 32'(ov_a),  0);
      check("rst_count", 32'(cnt_a), 0);
      check("rst_pc",    pc_a,       0);
      check("rst_instr", instr_a,    0);
      check("rst_p4",    p4_a,       0);

      // basic streaming
      rst_a = 0; ordy_a = 1; #1;
      check("t1_req0",  32'(req_a), 1);
      check("t1_addr0", addr_a,     0);
      check("t1_ov0",   32'(ov_a),  0);
      cyc(); #1;
      check("t1_addr1", addr_a,     4);
      check("t1_ov1",   32'(ov_a),  0);
      cyc(); #1;
      check("t1_ov2",    32'(ov_a), 1);
      check("t1_pc2",    pc_a,      0);
      check("t1_instr2", instr_a,   K);
      check("t1_p4_2",   p4_a,      4);
      for (int i = 3; i <= 5; i++) begin
         cyc(); #1;
         check("t1_pc",    pc_a,    32'(4 * (i - 2)));
         check("t1_instr", instr_a, 32'(4 * (i - 2)) ^ K);
         check("t1_p4",    p4_a,    32'(4 * (i - 1)));
      end

      // decode backpressure
      for (int i = 6; i <= 15; i++) begin
         cyc(); ordy_a = 0; #1;
         if (i == 7) check("t2_req_on",  32'(req_a), 1);
         if (i == 8) check("t2_req_off", 32'(req_a), 0);
      end
      check("t2_count", 32'(cnt_a), 4);
      check("t2_req",   32'(req_a), 0);
      check("t2_head",  pc_a,       16);
      check("t2_addr",  addr_a,     32);
      for (int i = 16; i <= 21; i++) begin
         cyc(); ordy_a = 1; #1;
         check("t2_ov", 32'(ov_a), 1);
         check("t2_pc", pc_a,      32'(16 + 4 * (i - 16)));
      end
      check("t2_addr21", addr_a, 48);

      // stall
      for (int i = 22; i <= 26; i++) begin
         cyc(); pw_a = 0; #1;
         check("t4_req",  32'(req_a), 0);
         check("t4_addr", addr_a,     52);
      end
      check("t4_count", 32'(cnt_a), 0);
      check("t4_ov",    32'(ov_a),  0);
      cyc(); pw_a = 1; #1;
      check("t4_req_rel",  32'(req_a), 1);
      check("t4_addr_rel", addr_a,     52);
      cyc(); #1;
      cyc(); #1;
      check("t4_ov29",    32'(ov_a), 1);
      check("t4_pc29",    pc_a,      52);
      check("t4_instr29", instr_a,   32'd52 ^ K);

      // redirect with stall and pop on a non-empty queue
      cyc(); rv_a = 1; rpc_a = 32'h200; pw_a = 0; #1;
      check("t5_head", pc_a,       56);
      check("t5_req",  32'(req_a), 0);
      cyc(); rv_a = 0; #1;
      check("t5_ov31",   32'(ov_a),  0);
      check("t5_cnt31",  32'(cnt_a), 0);
      check("t5_addr31", addr_a,     32'h200);
      check("t5_req31",  32'(req_a), 0);
      cyc(); #1;
      check("t5_ov32",   32'(ov_a), 0);
      check("t5_addr32", addr_a,    32'h200);
      cyc(); pw_a = 1; #1;
      check("t5_req33",  32'(req_a), 1);
      check("t5_addr33", addr_a,     32'h200);
      cyc(); #1;
      check("t5_ov34", 32'(ov_a), 0);
      cyc(); #1;
      check("t5_ov35",    32'(ov_a), 1);
      check("t5_pc35",    pc_a,      32'h200);
      check("t5_instr35", instr_a,   32'h200 ^ K);
      check("t5_p4_35",   p4_a,      32'h204);

      // MEM_LAT=3: wrap of PC and PC+4
      cyc(); rst_b = 0; #1;
      check("t6_req0",  32'(req_b), 1);
      check("t6_addr0", addr_b,     32'hFFFF_FFF8);
      for (int i = 1; i <= 7; i++) begin
         cyc(); #1;
         if (i == 2) check("t6_addr2", addr_b, 0);
         if (i == 3) check("t6_addr3", addr_b, 4);
         if (i == 3) check("t6_ov3",   32'(ov_b), 0);
         if (i == 4) check("t6_req4",  32'(req_b), 0);
         if (i == 4) check("t6_pc4",   pc_b, 32'hFFFF_FFF8);
         if (i == 4) check("t6_p4_4",  p4_b, 32'hFFFF_FFFC);
         if (i == 5) check("t6_pc5",   pc_b, 32'hFFFF_FFFC);
         if (i == 5) check("t6_p4_5",  p4_b, 0);
         if (i == 6) check("t6_pc6",   pc_b, 0);
         if (i == 6) check("t6_ins6",  instr_b, K);
         if (i == 7) check("t6_pc7",   pc_b, 4);
      end

      // asynchronous reset mid-stream
      #1; rst_b = 1; #1;
      check("t6_rst_ov",  32'(ov_b),  0);
      check("t6_rst_cnt", 32'(cnt_b), 0);
      check("t6_rst_req", 32'(req_b), 0);
      check("t6_rst_pc",  pc_b,       0);
      cyc();
      cyc(); rst_b = 0; #1;
      check("t3_addr0", addr_b,     32'hFFFF_FFF8);
      check("t3_ov0",   32'(ov_b),  0);
      for (int i = 1; i <= 2; i++) begin
         cyc(); #1;
         check("t3_drop_ov", 32'(ov_b), 0);
      end

      // redirect with three requests in flight
      cyc(); rv_b = 1; rpc_b = 32'h100; #1;
      check("t3_req_rd", 32'(req_b), 0);
      cyc(); rv_b = 0; #1;
      check("t3_cnt4",  32'(cnt_b), 0);
      check("t3_ov4",   32'(ov_b),  0);
      check("t3_req4",  32'(req_b), 1);
      check("t3_addr4", addr_b,     32'h100);
      cyc(); #1;
      check("t3_ov5",   32'(ov_b), 0);
      check("t3_addr5", addr_b,    32'h104);
      cyc(); #1;
      check("t3_ov6", 32'(ov_b), 0);
      cyc(); #1;
      check("t3_ov7",   32'(ov_b),  0);
      check("t3_req7",  32'(req_b), 1);
      check("t3_addr7", addr_b,     32'h10C);
      cyc(); #1;
      check("t3_ov8",  32'(ov_b), 1);
      check("t3_pc8",  pc_b,      32'h100);
      check("t3_ins8", instr_b,   32'h100 ^ K);
      cyc(); #1;
      check("t3_pc9", pc_b, 32'h104);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
